// File: rtl/nco_tdm_multich.sv
// Time-division-multiplexed multi-channel NCO: one accumulator adder and one dual-read
// quarter-wave sin ROM shared by NCH round-robin slots. Optional macro: NCO_TDM_DITHER_EN.
`timescale 1ns/1ps
module nco_tdm_multich #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned APR  = 32,
  parameter int unsigned APRP = 16,
  parameter int unsigned RAW  = 10,
  parameter int unsigned MPR  = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clken,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_ch,
  input  logic [APR-1:0]  cfg_phi_inc,
  input  logic [APRP-1:0] cfg_phi_ofs,
  input  logic            cfg_acc_clr,
  input  logic [APR-1:0]  freq_mod_i,
  input  logic [APRP-1:0] phase_mod_i,
  output logic [MPR-1:0]  fsin_o,
  output logic [MPR-1:0]  fcos_o,
  output logic [3:0]      out_ch,
  output logic            out_valid,
  output logic            sync_o
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned RW = 1 << RAW;
  localparam int unsigned FB = 56;

  // Quarter-wave table word k: round((2^(MPR-1)-1) * sin((k+0.5)*pi/2^(RAW+1))),
  // evaluated at elaboration with a Q56 Taylor series so no init file is needed.
  function automatic logic [MPR-2:0] sin_word(input int k);
    logic signed [127:0] pi_q, x, term, sum, amp;
    pi_q = 128'sh3243F6A8885A309;
    x    = (pi_q * 128'(2 * k + 1) + (128'sd1 <<< (RAW + 1))) >>> (RAW + 2);
    term = x;
    sum  = x;
    for (int n = 1; n <= 11; n++) begin
      term = (term * x) >>> FB;
      term = (term * x) >>> FB;
      term = -(term / 128'(2 * n * (2 * n + 1)));
      sum  = sum + term;
    end
    amp = 128'((1 << (MPR - 1)) - 1);
    return (MPR-1)'((sum * amp + (128'sd1 <<< (FB - 1))) >>> FB);
  endfunction

  logic [MPR-2:0] rom [RW];
  for (genvar k = 0; k < int'(RW); k++) begin : g_rom
    localparam logic [MPR-2:0] WORD = sin_word(k);
    assign rom[k] = WORD;
  end

  logic [CW-1:0]   slot;
  logic [APR-1:0]  acc     [NCH];
  logic [APR-1:0]  phi_inc [NCH];
  logic [APRP-1:0] phi_ofs [NCH];

  logic          cfg_hit;
  logic [CW-1:0] cfg_idx;
  assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < 5'(NCH));
  assign cfg_idx = CW'(cfg_ch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (clken) begin
      if (slot == CW'(NCH - 1)) slot <= '0;
      else                      slot <= slot + CW'(1);
    end
  end

  // Channel registers; a clear on the same edge overrides the slot's S0 update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        acc[i]     <= '0;
        phi_inc[i] <= '0;
        phi_ofs[i] <= '0;
      end
    end else begin
      if (clken) acc[slot] <= acc[slot] + phi_inc[slot] + freq_mod_i;
      if (cfg_hit) begin
        phi_inc[cfg_idx] <= cfg_phi_inc;
        phi_ofs[cfg_idx] <= cfg_phi_ofs;
        if (cfg_acc_clr) acc[cfg_idx] <= '0;
      end
    end
  end

  // Per-slot operands (offset, phase modulation) are captured together with the slot in S0.
  logic [APRP-1:0] s1_acc, s1_ofs, s1_pm;
  logic [CW-1:0]   s1_ch, s2_ch, s3_ch, s4_ch;
  logic [1:0]      s2_q, s3_q, s4_q;
  logic [RAW-1:0]  s2_idx, s3_sin_addr, s3_cos_addr;
  logic [MPR-2:0]  s4_sin_mag, s4_cos_mag;
  logic [3:0]      vld;
  logic [APRP-1:0] p;
  logic            unused_p;

`ifdef NCO_TDM_DITHER_EN
  localparam int unsigned DW = APRP - 2 - RAW;
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      lfsr <= 16'hACE1;
    else if (clken) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign p = s1_acc + s1_ofs + s1_pm + APRP'(lfsr & 16'((32'd1 << DW) - 32'd1));
`else
  assign p = s1_acc + s1_ofs + s1_pm;
`endif
  assign unused_p = ^p;

  logic [MPR-1:0] sin_ext, cos_ext;
  assign sin_ext = {1'b0, s4_sin_mag};
  assign cos_ext = {1'b0, s4_cos_mag};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_acc      <= '0;
      s1_ofs      <= '0;
      s1_pm       <= '0;
      s1_ch       <= '0;
      s2_q        <= '0;
      s2_idx      <= '0;
      s2_ch       <= '0;
      s3_q        <= '0;
      s3_sin_addr <= '0;
      s3_cos_addr <= '0;
      s3_ch       <= '0;
      s4_q        <= '0;
      s4_sin_mag  <= '0;
      s4_cos_mag  <= '0;
      s4_ch       <= '0;
      vld         <= '0;
      fsin_o      <= '0;
      fcos_o      <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      sync_o      <= 1'b0;
    end else if (clken) begin
      s1_acc      <= acc[slot][APR-1 -: APRP];
      s1_ofs      <= phi_ofs[slot];
      s1_pm       <= phase_mod_i;
      s1_ch       <= slot;
      s2_q        <= p[APRP-1 -: 2];
      s2_idx      <= p[APRP-3 -: RAW];
      s2_ch       <= s1_ch;
      s3_q        <= s2_q;
      s3_sin_addr <= s2_q[0] ? ~s2_idx : s2_idx;
      s3_cos_addr <= s2_q[0] ? s2_idx : ~s2_idx;
      s3_ch       <= s2_ch;
      s4_q        <= s3_q;
      s4_sin_mag  <= rom[s3_sin_addr];
      s4_cos_mag  <= rom[s3_cos_addr];
      s4_ch       <= s3_ch;
      vld         <= {vld[2:0], 1'b1};
      fsin_o      <= s4_q[1]             ? -sin_ext : sin_ext;
      fcos_o      <= (s4_q[1] ^ s4_q[0]) ? -cos_ext : cos_ext;
      out_ch      <= 4'(s4_ch);
      out_valid   <= vld[3];
      sync_o      <= vld[3] && (s4_ch == '0);
    end
  end

endmodule

// File: tb/tb_nco_tdm_multich.sv
// Bench for nco_tdm_multich: per-cycle comparison against a slot/phase model built from the
// channel rules, directed scenarios with hand-derived values, then randomized traffic.
`timescale 1ns/1ps
module tb_nco_tdm_multich;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset, clken, cfg_we, cfg_acc_clr;
  logic [3:0]  cfg_ch;
  logic [31:0] cfg_phi_inc, freq_mod_i;
  logic [15:0] cfg_phi_ofs, phase_mod_i;
  logic [11:0] fsin_o, fcos_o;
  logic [3:0]  out_ch;
  logic        out_valid, sync_o;

  nco_tdm_multich #(.NCH(NCH), .APR(32), .APRP(16), .RAW(10), .MPR(12)) dut (
    .clk(clk), .reset(reset), .clken(clken), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_phi_inc(cfg_phi_inc), .cfg_phi_ofs(cfg_phi_ofs), .cfg_acc_clr(cfg_acc_clr),
    .freq_mod_i(freq_mod_i), .phase_mod_i(phase_mod_i), .fsin_o(fsin_o), .fcos_o(fcos_o),
    .out_ch(out_ch), .out_valid(out_valid), .sync_o(sync_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int rom_m [1024];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: channel state, slot counter, and the phase of each sample over the last 5 clken edges.
  logic [31:0] m_acc [NCH];
  logic [31:0] m_inc [NCH];
  logic [15:0] m_ofs [NCH];
  int          m_slot, m_cnt;
  logic [15:0] d_p  [5];
  int          d_ch [5];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = '0; m_inc[i] = '0; m_ofs[i] = '0;
      end
      for (int i = 0; i < 5; i++) begin
        d_p[i] = '0; d_ch[i] = 0;
      end
      m_slot = 0;
      m_cnt  = 0;
    end else begin
      if (clken) begin
        for (int i = 4; i > 0; i--) begin
          d_p[i]  = d_p[i-1];
          d_ch[i] = d_ch[i-1];
        end
        d_p[0]  = m_acc[m_slot][31:16] + m_ofs[m_slot] + phase_mod_i;
        d_ch[0] = m_slot;
        m_acc[m_slot] = m_acc[m_slot] + m_inc[m_slot] + freq_mod_i;
        m_slot = (m_slot + 1) % NCH;
        if (m_cnt < 5) m_cnt++;
      end
      if (cfg_we && int'(cfg_ch) < NCH) begin
        m_inc[int'(cfg_ch)] = cfg_phi_inc;
        m_ofs[int'(cfg_ch)] = cfg_phi_ofs;
        if (cfg_acc_clr) m_acc[int'(cfg_ch)] = '0;
      end
    end
  end

  // Signed sin/cos of a 16-bit phase from quadrant symmetry of the quarter-wave table.
  function automatic void exp_sc(input logic [15:0] ph, output int s, output int c);
    int q, idx, ms, mc;
    q   = int'(ph[15:14]);
    idx = int'(ph[13:4]);
    ms  = (q % 2 == 0) ? rom_m[idx] : rom_m[1023 - idx];
    mc  = (q % 2 == 0) ? rom_m[1023 - idx] : rom_m[idx];
    s   = (q >= 2) ? -ms : ms;
    c   = (q == 1 || q == 2) ? -mc : mc;
  endfunction

  always @(negedge clk) begin : cmp
    int es, ec;
    chk("out_valid", int'(out_valid), (m_cnt >= 5) ? 1 : 0);
    if (m_cnt >= 5) begin
      exp_sc(d_p[4], es, ec);
      chk("fsin", int'($signed(fsin_o)), es);
      chk("fcos", int'($signed(fcos_o)), ec);
      chk("out_ch", int'(out_ch), d_ch[4]);
      chk("sync", int'(sync_o), (d_ch[4] == 0) ? 1 : 0);
    end
  end

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_ch = '0; cfg_phi_inc = '0; cfg_phi_ofs = '0; cfg_acc_clr = 1'b0;
    freq_mod_i = '0; phase_mod_i = '0;
  endtask

  task automatic cfg_write(input int ch, input logic [31:0] inc, input logic [15:0] ofs,
                           input logic clr);
    cfg_ch = 4'(ch); cfg_phi_inc = inc; cfg_phi_ofs = ofs; cfg_acc_clr = clr; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; cfg_acc_clr = 1'b0;
  endtask

  task automatic wait_ch(input int ch, output int s, output int c);
    s = 0; c = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (out_valid && int'(out_ch) == ch) begin
        s = int'($signed(fsin_o));
        c = int'($signed(fcos_o));
        return;
      end
    end
    chk("wait_ch_timeout", 0, 1);
  endtask

  initial begin
    int s, c;
    for (int k = 0; k < 1024; k++)
      rom_m[k] = $rtoi(2047.0 * $sin((k + 0.5) * 3.14159265358979323846 / 2048.0) + 0.5);
    chk("model_R0", rom_m[0], 2);
    chk("model_R1023", rom_m[1023], 2047);

    idle_inputs();
    clken = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fsin", int'(fsin_o), 0);
    chk("rst_fcos", int'(fcos_o), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sync", int'(sync_o), 0);

    // Latency and idle pattern
    reset = 1'b0;
    clken = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("lat_valid_low", int'(out_valid), 0);
    end
    @(negedge clk);
    chk("lat_valid_high", int'(out_valid), 1);
    chk("first_ch", int'(out_ch), 0);
    chk("first_sin", int'($signed(fsin_o)), 2);
    chk("first_cos", int'($signed(fcos_o)), 2047);
    chk("first_sync", int'(sync_o), 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("idle_ch_seq", int'(out_ch), k);
    end

    // Quarter-turn rotation on channel 0
    cfg_write(0, 32'h4000_0000, 16'h0000, 1'b1);
    s = 2;
    for (int t = 0; t < 8 && s == 2; t++) wait_ch(0, s, c);
    chk("rot_sin1", s, 2047);   chk("rot_cos1", c, -2);
    wait_ch(0, s, c);
    chk("rot_sin2", s, -2);     chk("rot_cos2", c, -2047);
    wait_ch(0, s, c);
    chk("rot_sin3", s, -2047);  chk("rot_cos3", c, 2);
    wait_ch(0, s, c);
    chk("rot_sin0", s, 2);      chk("rot_cos0", c, 2047);

    // Static half-turn offset on channel 2
    cfg_write(2, 32'h0, 16'h8000, 1'b0);
    repeat (10) @(negedge clk);
    wait_ch(2, s, c);
    chk("ofs_sin", s, -2);
    chk("ofs_cos", c, -2047);

    // Frequency modulation cancelling channel 1's increment
    cfg_write(1, 32'h1000_0000, 16'h0000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      freq_mod_i = (m_slot == 1) ? 32'hF000_0000 : 32'h0;
      @(negedge clk);
      if (i > 12 && out_valid && out_ch == 4'd1) begin
        chk("fm_sin", int'($signed(fsin_o)), 2);
        chk("fm_cos", int'($signed(fcos_o)), 2047);
      end
    end
    freq_mod_i = '0;

    // Accumulator wrap: 0 -> FFFF_FFFF -> FFFF_FFFE
    cfg_write(3, 32'hFFFF_FFFF, 16'h0000, 1'b1);
    repeat (12) @(negedge clk);
    wait_ch(3, s, c);
    chk("wrap_sin", s, -2);
    chk("wrap_cos", c, 2047);

    // Clock-enable stall mid-frame
    repeat (2) @(negedge clk);
    clken = 1'b0;
    repeat (7) @(negedge clk);
    clken = 1'b1;
    repeat (12) @(negedge clk);

    // Clear on channel 3 during its own S0 edge
    for (int t = 0; t < 8 && m_slot != 3; t++) @(negedge clk);
    cfg_write(3, 32'h1234_5678, 16'h0000, 1'b1);
    repeat (8) @(negedge clk);
    chk("clr_ch", int'(out_ch), 3);
    chk("clr_sin", int'($signed(fsin_o)), 2);
    chk("clr_cos", int'($signed(fcos_o)), 2047);

    // Out-of-range channel write is ignored
    cfg_write(5, 32'hDEAD_BEEF, 16'h1234, 1'b1);
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-frame
    #2 reset = 1'b1;
    #1;
    chk("arst_fsin", int'(fsin_o), 0);
    chk("arst_fcos", int'(fcos_o), 0);
    chk("arst_out_ch", int'(out_ch), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_sync", int'(sync_o), 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
      clken       = ($urandom_range(0, 9) != 0);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_ch      = 4'($urandom_range(0, 7));
      cfg_phi_inc = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 65535) << 12);
      cfg_phi_ofs = 16'($urandom);
      cfg_acc_clr = ($urandom_range(0, 3) == 0);
      freq_mod_i  = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'h0;
      phase_mod_i = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
    end
    @(negedge clk);
    idle_inputs();
    clken = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
